// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch-stage sequencer: state encoding,
// default widths and the absolute jump target table.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   localparam int PW = 10;
   localparam int OW = 6;
   localparam int LW = 3;

   localparam logic [PW-1:0] BR_LUT [2**LW] = '{
      10'h000, 10'h010, 10'h050, 10'h100,
      10'h180, 10'h200, 10'h300, 10'h3F0
   };

endpackage

// File: rtl/fetch_seq_if.sv
// Control/status bundle between the decoder side and the fetch sequencer.
// CycleCt exists only when CYCLE_COUNT_EN is defined.
interface fetch_seq_if #(
   parameter int PW = 10,
   parameter int OW = 6,
   parameter int LW = 3
);
   logic                 Start;
   logic                 Halt;
   logic                 BranchEn;
   logic                 Zero;
   logic signed [OW-1:0] Offset;
   logic                 Jump;
   logic [LW-1:0]        JumpIdx;
   logic [PW-1:0]        ProgCtr;
   logic                 Running;
   logic                 Ack;
`ifdef CYCLE_COUNT_EN
   logic [15:0]          CycleCt;

   modport master (
      output Start, Halt, BranchEn, Zero, Offset, Jump, JumpIdx,
      input  ProgCtr, Running, Ack, CycleCt
   );
   modport slave (
      input  Start, Halt, BranchEn, Zero, Offset, Jump, JumpIdx,
      output ProgCtr, Running, Ack, CycleCt
   );
`else
   modport master (
      output Start, Halt, BranchEn, Zero, Offset, Jump, JumpIdx,
      input  ProgCtr, Running, Ack
   );
   modport slave (
      input  Start, Halt, BranchEn, Zero, Offset, Jump, JumpIdx,
      output ProgCtr, Running, Ack
   );
`endif
endinterface

// File: rtl/fetch_seq_branch_lut.sv
// Combinational jump-index to absolute-target lookup over the package table.
module branch_lut #(
   parameter int PW = fetch_pkg::PW,
   parameter int LW = fetch_pkg::LW
) (
   input  logic [LW-1:0] idx_i,
   output logic [PW-1:0] tgt_o
);
   import fetch_pkg::*;

   assign tgt_o = PW'(BR_LUT[idx_i]);

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: run handshake FSM, program counter and branch/jump
// resolution. Define CYCLE_COUNT_EN to add the saturating RUN-cycle counter.
module fetch_seq #(
   parameter int PW = fetch_pkg::PW,
   parameter int OW = fetch_pkg::OW,
   parameter int LW = fetch_pkg::LW
) (
   input  logic       Clk,
   input  logic       Reset,
   fetch_seq_if.slave bus
);
   import fetch_pkg::*;

   fetch_state_t  state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [PW-1:0] jump_tgt;
   logic          running_q;
   logic          ack_q;

   function automatic logic signed [PW-1:0] sext_off(input logic signed [OW-1:0] off);
      return {{(PW-OW){off[OW-1]}}, off};
   endfunction

   branch_lut #(.PW(PW), .LW(LW)) u_lut (
      .idx_i (bus.JumpIdx),
      .tgt_o (jump_tgt)
   );

   // Next state/PC; all sums are naturally modulo 2**PW by width.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) state_d = LOAD;
         end
         LOAD: begin
            pc_d = '0;
            if (!bus.Start) state_d = RUN;
         end
         RUN: begin
            if (bus.Start) begin
               state_d = LOAD;
               pc_d    = '0;
            end else if (bus.Halt) begin
               state_d = DONE;
            end else if (bus.Jump) begin
               pc_d = jump_tgt;
            end else if (bus.BranchEn && bus.Zero) begin
               pc_d = pc_q + $unsigned(sext_off(bus.Offset));
            end else begin
               pc_d = pc_q + PW'(1);
            end
         end
         DONE: begin
            if (bus.Start) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // Running/Ack are registered from the next state so they track state_q exactly.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= (state_d == RUN);
         ack_q     <= (state_d == DONE);
      end
   end

   assign bus.ProgCtr = pc_q;
   assign bus.Running = running_q;
   assign bus.Ack     = ack_q;

`ifdef CYCLE_COUNT_EN
   logic [15:0] cyc_q, cyc_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      cyc_d = cyc_q;
      if (state_q == LOAD)     cyc_d = '0;
      else if (state_q == RUN) cyc_d = sat_inc16(cyc_q);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) cyc_q <= '0;
      else        cyc_q <= cyc_d;
   end

   assign bus.CycleCt = cyc_q;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed vector table, multi-cycle corner sequences and
// randomized traffic against a behavioural model.
module tb_fetch_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_seq_if bus ();

   fetch_seq dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      bit         st, h, b, z, j;
      logic [5:0] off;
      logic [2:0] idx;
      int         pc;
      bit         run, ack;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t V(bit st, bit h, bit b, bit z, bit j,
                              logic [5:0] off, logic [2:0] idx,
                              int pc, bit run, bit ack);
      vec_t v;
      v.st = st; v.h = h; v.b = b; v.z = z; v.j = j;
      v.off = off; v.idx = idx; v.pc = pc; v.run = run; v.ack = ack;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit st, input bit h, input bit b, input bit z,
                        input bit j, input logic [5:0] off, input logic [2:0] idx);
      bus.Start    = st;
      bus.Halt     = h;
      bus.BranchEn = b;
      bus.Zero     = z;
      bus.Jump     = j;
      bus.Offset   = off;
      bus.JumpIdx  = idx;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: mode as a plain int, PC as integer arithmetic mod 1024.
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;
   int m_mode, m_pc, m_cyc;
   int lut [8] = '{0, 'h010, 'h050, 'h100, 'h180, 'h200, 'h300, 'h3F0};

   function automatic void model_reset();
      m_mode = M_IDLE; m_pc = 0; m_cyc = 0;
   endfunction

   function automatic void model_edge(bit st, bit h, bit b, bit z, bit j,
                                      logic [5:0] off, logic [2:0] idx);
      int prev = m_mode;
      int o = (off >= 32) ? int'(off) - 64 : int'(off);
      case (prev)
         M_IDLE: if (st) m_mode = M_LOAD;
         M_LOAD: begin
            m_pc = 0;
            if (!st) m_mode = M_RUN;
         end
         M_RUN: begin
            if (st) begin m_mode = M_LOAD; m_pc = 0; end
            else if (h) m_mode = M_DONE;
            else if (j) m_pc = lut[idx];
            else if (b && z) m_pc = ((m_pc + o) % 1024 + 1024) % 1024;
            else m_pc = (m_pc + 1) % 1024;
         end
         default: if (st) m_mode = M_LOAD;
      endcase
      if (prev == M_LOAD) m_cyc = 0;
      else if (prev == M_RUN && m_cyc < 65535) m_cyc++;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit st, h, b, z, j;
      logic [5:0] off;
      logic [2:0] idx;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0);
      repeat (2) tick();
      chk("reset_pc", bus.ProgCtr, 0);
      chk("reset_running", bus.Running, 0);
      chk("reset_ack", bus.Ack, 0);
      rst_n = 1'b1;
      drive(0, 1, 1, 1, 1, 6'h05, 3'd4);   // controls ignored in IDLE
      tick();
      chk("idle_pc", bus.ProgCtr, 0);
      chk("idle_running", bus.Running, 0);

      // Directed table
      vecs.push_back(V(1,0,0,0,0,6'h00,3'd0,'h000,0,0));
      vecs.push_back(V(1,0,0,0,0,6'h00,3'd0,'h000,0,0));
      vecs.push_back(V(1,0,0,0,0,6'h00,3'd0,'h000,0,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h000,1,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h001,1,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h002,1,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h003,1,0));
      vecs.push_back(V(0,0,0,0,1,6'h00,3'd1,'h010,1,0));
      vecs.push_back(V(0,0,1,1,0,6'h10,3'd0,'h020,1,0));
      vecs.push_back(V(0,0,1,0,0,6'h3C,3'd0,'h021,1,0));
      vecs.push_back(V(0,0,1,1,0,6'h3F,3'd0,'h020,1,0));
      vecs.push_back(V(0,0,1,1,0,6'h3C,3'd0,'h01C,1,0));
      vecs.push_back(V(0,0,1,1,1,6'h3C,3'd2,'h050,1,0));
      vecs.push_back(V(0,0,0,0,1,6'h00,3'd7,'h3F0,1,0));
      vecs.push_back(V(0,0,1,1,0,6'h0F,3'd0,'h3FF,1,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h000,1,0));
      vecs.push_back(V(0,0,1,1,0,6'h3E,3'd0,'h3FE,1,0));
      vecs.push_back(V(0,0,0,0,1,6'h00,3'd6,'h300,1,0));
      vecs.push_back(V(0,1,1,1,1,6'h05,3'd3,'h300,0,1));
      vecs.push_back(V(0,0,0,0,1,6'h00,3'd1,'h300,0,1));
      vecs.push_back(V(1,0,0,0,0,6'h00,3'd0,'h300,0,0));
      vecs.push_back(V(1,0,0,0,1,6'h00,3'd7,'h000,0,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h000,1,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h001,1,0));
      vecs.push_back(V(1,0,0,0,0,6'h00,3'd0,'h000,0,0));
      vecs.push_back(V(0,0,0,0,0,6'h00,3'd0,'h000,1,0));

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].h, vecs[i].b, vecs[i].z, vecs[i].j,
               vecs[i].off, vecs[i].idx);
         tick();
         chk($sformatf("vec%0d_pc", i), bus.ProgCtr, vecs[i].pc);
         chk($sformatf("vec%0d_running", i), bus.Running, vecs[i].run);
         chk($sformatf("vec%0d_ack", i), bus.Ack, vecs[i].ack);
      end

      // Asynchronous reset in the middle of RUN
      drive(0, 0, 0, 0, 1, 6'h00, 3'd1); tick();
      drive(0, 0, 1, 1, 0, 6'h13, 3'd0); tick();
      chk("pre_reset_pc", bus.ProgCtr, 'h023);
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_pc", bus.ProgCtr, 0);
      chk("async_reset_running", bus.Running, 0);
      chk("async_reset_ack", bus.Ack, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("post_reset_idle_pc", bus.ProgCtr, 0);
         chk("post_reset_idle_running", bus.Running, 0);
      end

      // Halt with Jump, hold in DONE, restart
      drive(1, 0, 0, 0, 0, 6'h00, 3'd0); tick();
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0); tick();
      drive(0, 0, 0, 0, 1, 6'h00, 3'd2); tick();
      drive(0, 0, 1, 1, 0, 6'h30, 3'd0); tick();
      chk("halt_setup_pc", bus.ProgCtr, 'h040);
      drive(0, 1, 1, 1, 1, 6'h01, 3'd5); tick();
      chk("halt_ack", bus.Ack, 1);
      chk("halt_running", bus.Running, 0);
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("done_hold%0d_pc", k), bus.ProgCtr, 'h040);
         chk($sformatf("done_hold%0d_ack", k), bus.Ack, 1);
         tick();
      end
      drive(1, 0, 0, 0, 0, 6'h00, 3'd0); tick();
      chk("restart_ack", bus.Ack, 0);
      chk("restart_running", bus.Running, 0);
      tick();
      chk("restart_pc", bus.ProgCtr, 0);
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0); tick();

`ifdef CYCLE_COUNT_EN
      // Halt on the 7th RUN cycle
      drive(1, 0, 0, 0, 0, 6'h00, 3'd0); tick(); tick();
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0); tick();
      chk("cyc_run_start", bus.CycleCt, 0);
      repeat (6) tick();
      drive(0, 1, 0, 0, 0, 6'h00, 3'd0); tick();
      chk("cyc_at_halt", bus.CycleCt, 7);
      chk("cyc_halt_ack", bus.Ack, 1);
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0);
      repeat (3) tick();
      chk("cyc_done_hold", bus.CycleCt, 7);
      drive(1, 0, 0, 0, 0, 6'h00, 3'd0); tick(); tick();
      chk("cyc_cleared", bus.CycleCt, 0);
      drive(0, 0, 0, 0, 0, 6'h00, 3'd0); tick();
`endif

      // Randomized traffic against the model
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         st  = ($urandom_range(0, 19) == 0);
         h   = ($urandom_range(0, 24) == 0);
         j   = ($urandom_range(0, 5) == 0);
         b   = ($urandom_range(0, 2) == 0);
         z   = $urandom_range(0, 1) != 0;
         off = 6'($urandom_range(0, 63));
         idx = 3'($urandom_range(0, 7));
         drive(st, h, b, z, j, off, idx);
         tick();
         model_edge(st, h, b, z, j, off, idx);
         chk("rand_pc", bus.ProgCtr, m_pc);
         chk("rand_running", bus.Running, m_mode == M_RUN);
         chk("rand_ack", bus.Ack, m_mode == M_DONE);
`ifdef CYCLE_COUNT_EN
         chk("rand_cyc", bus.CycleCt, m_cyc);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
